n_term_single2_turnaround_bist: RTL
===================================

Name: n_term_single2_turnaround_bist

Overview:
- North-edge terminal tile for the single2 routing fabric, the opposite end of the south-edge terminal turnaround.
- Turns northbound wires (N1END, N2MID, N2END, N4END, NN4END) back south onto S1BEG, S2BEG, S2BEGb, S4BEG and SS4BEG, with index reversal.
- Unlike the purely combinational south terminal, the path is registered and adds a built-in LFSR pattern generator and loopback checker for fabric wire test.

Parameters:
PIPE_STAGES, 1, turnaround register stages in PASS mode (legal 1..3)
LOOP_DELAY, 4, cycles from this block's output, through the fabric loop, back to its input (legal 1..16)
LFSR_SEED, 52'h0_0000_0000_0001, LFSR reset/reload value (nonzero)
ERR_W, 16, error counter width

Ports:
UserCLK  in  1  tile clock, all state on rising edge
rst  in  1  synchronous active-high reset
N1END  in  4  northbound single wires
N2MID  in  8  northbound double, mid tap
N2END  in  8  northbound double, end tap
N4END  in  16  northbound quad
NN4END  in  16  northbound long quad
S1BEG  out  4  southbound single wires
S2BEG  out  8  southbound double
S2BEGb  out  8  southbound double, b tap
S4BEG  out  16  southbound quad
SS4BEG  out  16  southbound long quad
mode_valid  in  1  mode request valid
mode  in  2  0 PASS, 1 HOLD, 2 GEN, 3 CHECK
mode_ready  out  1  request accepted when valid&ready
err_cnt  out  ERR_W  saturating mismatch count
err_flag  out  1  sticky mismatch indicator

Behaviour:
- Mapping:
  - m = {NN4END[15-i], N4END[15-i], N2END[7-i], N2MID[7-i], N1END[3-i]}, a 52-bit mapped bus.
  - Output register O = {SS4BEG, S4BEG, S2BEGb, S2BEG, S1BEG}, same field order.
- Reset (rst=1 at an edge):
  - State PASS.
  - O and all pipeline registers = 0.
  - lfsr = LFSR_SEED; history = 0.
  - err_cnt = 0, err_flag = 0, mode_ready = 1.
  - Reset mid-operation aborts any mode immediately.
- Pipeline:
  - PIPE_STAGES-1 internal stages always shift m every cycle, in every state.
  - In PASS, O loads the last stage, or m directly if PIPE_STAGES=1.
  - O at cycle t+PIPE_STAGES equals m sampled at cycle t.
- States: PASS, HOLD, GEN, WARM, CHECK.
- Handshake:
  - mode_ready = 1 in all states except WARM.
  - Accept on valid&ready; the new state is active from the next edge.
  - Requests during WARM are ignored and not queued.
  - Re-requesting the current mode is legal, and reloads the LFSR for modes 2 and 3.
- PASS: O updates per the pipeline rule.
- HOLD: O retains its value; lfsr retains its value.
- GEN (entry from any accept of mode 2):
  - lfsr reloads LFSR_SEED on the accept edge.
  - Each following cycle: O <= lfsr; lfsr <= {lfsr[50:0], lfsr[51]^lfsr[48]}.
  - The first GEN output is LFSR_SEED.
- WARM (on accepting mode 3):
  - err_cnt and err_flag clear; lfsr reloads; generation proceeds as in GEN.
  - Lasts exactly LOOP_DELAY cycles, then goes to CHECK.
  - No comparison is made in WARM.
- History:
  - A LOOP_DELAY-deep shift register of O, updated every cycle in all states.
  - exp = O from LOOP_DELAY cycles earlier.
- CHECK:
  - Generation continues.
  - Each cycle, if m != exp: err_cnt increments, saturating at all-ones, and err_flag <= 1.
  - err_flag is sticky until reset or the next mode-3 accept.
- Leaving CHECK or GEN to PASS: O takes the pipeline value on the next edge; err_cnt and err_flag hold.
- The LFSR never reaches zero given a nonzero seed.

Test Plan:
- PASS, PIPE_STAGES=1: N1END=4'b0001, N4END=16'h0001 at cycle t -> at t+1 S1BEG=4'b1000, S4BEG=16'h8000. With PIPE_STAGES=3 the same values appear at t+3.
- HOLD: accept mode 1 with SS4BEG=16'h00F0, then toggle all inputs for 10 cycles -> SS4BEG stays 16'h00F0 and mode_ready stays 1.
- GEN, seed 1: accept mode 2 -> next cycles' S1BEG[0] sequence is 1, then S1BEG=4'b0010, then 4'b0100. Exactly 52-bit LFSR steps.
- CHECK: loop O back to inputs through a 4-cycle delay model with inverse mapping -> mode_ready=0 for 4 cycles and err_cnt=0 after 100 cycles. Flip NN4END[3] for one cycle -> err_cnt=1, err_flag=1, and the flag stays set.
- Saturation, ERR_W=2: CHECK with inputs tied 0 -> err_cnt reaches 3 and holds. A mode-3 re-request -> err_cnt=0, err_flag=0.
- Reset mid-CHECK with err_cnt=5: assert rst for one edge -> all outputs 0, err_cnt=0, state PASS, mode_ready=1. A mode request during WARM -> ignored.

Source files
------------

// File: rtl/n_term_single2_turnaround_bist.sv
// n_term_single2_turnaround_bist: north-edge single2 turnaround with registered path and LFSR loopback BIST
module n_term_single2_turnaround_bist #(
    parameter int          PIPE_STAGES = 1,
    parameter int          LOOP_DELAY  = 4,
    parameter logic [51:0] LFSR_SEED   = 52'h0_0000_0000_0001,
    parameter int          ERR_W       = 16
) (
    input  logic             UserCLK,
    input  logic             rst,
    input  logic [3:0]       N1END,
    input  logic [7:0]       N2MID,
    input  logic [7:0]       N2END,
    input  logic [15:0]      N4END,
    input  logic [15:0]      NN4END,
    output logic [3:0]       S1BEG,
    output logic [7:0]       S2BEG,
    output logic [7:0]       S2BEGb,
    output logic [15:0]      S4BEG,
    output logic [15:0]      SS4BEG,
    input  logic             mode_valid,
    input  logic [1:0]       mode,
    output logic             mode_ready,
    output logic [ERR_W-1:0] err_cnt,
    output logic             err_flag
);
    typedef enum logic [2:0] {PASS = 3'd0, HOLD = 3'd1, GEN = 3'd2, WARM = 3'd3, CHECK = 3'd4} state_t;
    localparam int WCW = $clog2(LOOP_DELAY + 1);

    state_t                       state_q, state_d;
    logic [51:0]                  m, pass_val, o_q, o_d, lfsr_q, lfsr_d, exp_val;
    logic [LOOP_DELAY-1:0][51:0]  hist_q, hist_d;
    logic [WCW-1:0]               warm_q, warm_d;
    logic [ERR_W-1:0]             err_q, err_d;
    logic                         flag_q, flag_d, ready_q, ready_d, accept, gen_on, mis, clr;

    always_comb begin
        for (int i = 0; i < 4; i++) m[i] = N1END[3-i];
        for (int i = 0; i < 8; i++) begin
            m[4+i]  = N2MID[7-i];
            m[12+i] = N2END[7-i];
        end
        for (int i = 0; i < 16; i++) begin
            m[20+i] = N4END[15-i];
            m[36+i] = NN4END[15-i];
        end
    end

    // Internal stages shift regardless of state so PASS resumes with fresh data.
    if (PIPE_STAGES == 1) begin : g_direct
        assign pass_val = m;
    end else begin : g_pipe
        logic [PIPE_STAGES-2:0][51:0] pipe_q, pipe_d;
        always_comb begin
            pipe_d[0] = m;
            for (int i = 1; i < PIPE_STAGES - 1; i++) pipe_d[i] = pipe_q[i-1];
        end
        always_ff @(posedge UserCLK) pipe_q <= rst ? '0 : pipe_d;
        assign pass_val = pipe_q[PIPE_STAGES-2];
    end

    always_comb begin
        hist_d[0] = o_q;
        for (int i = 1; i < LOOP_DELAY; i++) hist_d[i] = hist_q[i-1];
        exp_val = hist_q[LOOP_DELAY-1];
        accept  = mode_valid && ready_q;
        clr     = accept && mode == 2'd3;
        gen_on  = state_q inside {GEN, WARM, CHECK};
        o_d     = state_q == PASS ? pass_val : state_q == HOLD ? o_q : lfsr_q;
        lfsr_d  = (accept && mode[1]) ? LFSR_SEED :
                  gen_on ? {lfsr_q[50:0], lfsr_q[51] ^ lfsr_q[48]} : lfsr_q;
        warm_d  = accept ? '0 : state_q == WARM ? warm_q + 1'b1 : warm_q;
        // Mode codes line up with PASS/HOLD/GEN/WARM, so a mode-3 accept lands in WARM.
        state_d = accept ? state_t'({1'b0, mode}) :
                  (state_q == WARM && warm_q == WCW'(LOOP_DELAY - 1)) ? CHECK : state_q;
        mis     = state_q == CHECK && m != exp_val;
        err_d   = clr ? '0 : (mis && !(&err_q)) ? err_q + 1'b1 : err_q;
        flag_d  = clr ? 1'b0 : flag_q || mis;
        ready_d = state_d != WARM;
    end

    always_ff @(posedge UserCLK) begin
        if (rst) begin
            state_q <= PASS;
            o_q     <= '0;
            lfsr_q  <= LFSR_SEED;
            hist_q  <= '0;
            warm_q  <= '0;
            err_q   <= '0;
            flag_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            lfsr_q  <= lfsr_d;
            hist_q  <= hist_d;
            warm_q  <= warm_d;
            err_q   <= err_d;
            flag_q  <= flag_d;
            ready_q <= ready_d;
        end
    end

    assign {SS4BEG, S4BEG, S2BEGb, S2BEG, S1BEG} = o_q;
    assign mode_ready = ready_q;
    assign err_cnt    = err_q;
    assign err_flag   = flag_q;
endmodule
